// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS execution controller: states, commands, defaults.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned CMD_W      = 2;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WB_CNT_W   = 8;

  localparam int unsigned DEF_DRAIN_CYCLES = 4;
  localparam int unsigned DEF_RST_CYCLES   = 2;

  // Instruction word the fetch stage flags as HALT.
  localparam logic [DATA_W-1:0] HALT_OPCODE = 32'hFFFF_FFFF;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4,
    ST_CPURST = 3'd5
  } state_e;

  typedef enum logic [CMD_W-1:0] {
    CMD_RUN       = 2'b00,
    CMD_STEP      = 2'b01,
    CMD_STOP      = 2'b10,
    CMD_CPU_RESET = 2'b11
  } cmd_e;

  // Captured write-back result.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_payload_t;

endpackage

// File: rtl/mips_exec_ctrl_if.sv
// Debug command handshake plus the write-back observation bus.
interface mips_exec_ctrl_if;
  import mips_ctrl_pkg::*;

  logic                  i_cmd_valid;
  logic [CMD_W-1:0]      i_cmd;
  logic                  o_cmd_ready;
  logic                  i_wb_regwrite;
  logic [REG_ADDR_W-1:0] i_wb_addr;
  logic [DATA_W-1:0]     i_wb_data;

  modport master (
    output i_cmd_valid, i_cmd, i_wb_regwrite, i_wb_addr, i_wb_data,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_wb_regwrite, i_wb_addr, i_wb_data,
    output o_cmd_ready
  );

endinterface

// File: rtl/mips_ctrl_sat_counter.sv
// Up-counter with synchronous clear and saturation at all-ones.
module mips_ctrl_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear wins over enable; hold once every bit is set.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mips_exec_ctrl.sv
// Execution controller: run/step/stop/reset sequencing, pipeline drain, write-back capture.
module mips_exec_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_exec_ctrl_if.slave       bus,
  input  logic                  i_halt_fetched,
  output logic                  o_pc_write,
  output logic                  o_cpu_rst,
  output logic [STATE_W-1:0]    o_state,
  output logic                  o_done,
  output logic [CNT_W-1:0]      o_cycle_count,
  output logic [REG_ADDR_W-1:0] o_last_wb_addr,
  output logic [DATA_W-1:0]     o_last_wb_data,
  output logic [WB_CNT_W-1:0]   o_wb_count
);

  // One down-counter serves both DRAIN and CPURST; size it for the longer one.
  localparam int unsigned DN_MAX = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
  localparam int unsigned DN_W   = (DN_MAX > 1) ? $clog2(DN_MAX) : 1;

  state_e              state_q, state_d;
  logic [DN_W-1:0]     dn_q, dn_d;
  logic                pc_write_q, pc_write_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic                cmd_acc_c;
  logic                cpurst_entry_c;
  cmd_e                cmd_c;
  wb_payload_t         last_wb_q;
  logic [WB_CNT_W-1:0] wb_cnt_q;

  assign cmd_c     = cmd_e'(bus.i_cmd);
  assign cmd_acc_c = bus.i_cmd_valid & ready_q;

  // Next state, down-counter and registered-output targets.
  always_comb begin
    state_d        = state_q;
    dn_d           = dn_q;
    pc_write_d     = 1'b0;
    cpu_rst_d      = 1'b0;
    done_d         = 1'b0;
    ready_d        = 1'b0;
    cpurst_entry_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_acc_c) begin
          case (cmd_c)
            CMD_RUN:       state_d = ST_RUN;
            CMD_STEP:      state_d = ST_STEP;
            CMD_CPU_RESET: state_d = ST_CPURST;
            default:       state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (cmd_acc_c && (cmd_c == CMD_CPU_RESET)) begin
          state_d = ST_CPURST;
        end else if (i_halt_fetched || (cmd_acc_c && (cmd_c == CMD_STOP))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_STEP: begin
        state_d = i_halt_fetched ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (dn_q == '0) begin
          state_d = ST_DONE;
        end else begin
          dn_d = dn_q - DN_W'(1);
        end
      end
      ST_DONE: begin
        if (cmd_acc_c && (cmd_c == CMD_CPU_RESET)) begin
          state_d = ST_CPURST;
        end
      end
      ST_CPURST: begin
        if (dn_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          dn_d = dn_q - DN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load the down-counter on entry to a timed state.
    if ((state_d == ST_DRAIN) && (state_q != ST_DRAIN)) begin
      dn_d = DN_W'(DRAIN_CYCLES - 1);
    end
    if ((state_d == ST_CPURST) && (state_q != ST_CPURST)) begin
      dn_d           = DN_W'(RST_CYCLES - 1);
      cpurst_entry_c = 1'b1;
    end

    pc_write_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    cpu_rst_d  = (state_d == ST_CPURST);
    ready_d    = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_DONE);
    done_d     = (state_d == ST_DRAIN) && (dn_d == '0);
  end

  // State register and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dn_q       <= '0;
      pc_write_q <= 1'b0;
      cpu_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      dn_q       <= dn_d;
      pc_write_q <= pc_write_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  // Write-back capture; suspended while the core is held in reset, cleared on entry to it.
  always_ff @(posedge clk) begin
    if (rst || cpurst_entry_c) begin
      last_wb_q <= '0;
      wb_cnt_q  <= '0;
    end else if ((state_q != ST_CPURST) && bus.i_wb_regwrite) begin
      last_wb_q <= '{addr: bus.i_wb_addr, data: bus.i_wb_data};
      wb_cnt_q  <= wb_cnt_q + WB_CNT_W'(1);
    end
  end

  // Counts cycles in which the PC is allowed to advance.
  mips_ctrl_sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cpurst_entry_c),
    .en    (pc_write_q),
    .count (o_cycle_count)
  );

  assign bus.o_cmd_ready = ready_q;
  assign o_pc_write      = pc_write_q;
  assign o_cpu_rst       = cpu_rst_q;
  assign o_done          = done_q;
  assign o_state         = state_q;
  assign o_last_wb_addr  = last_wb_q.addr;
  assign o_last_wb_data  = last_wb_q.data;
  assign o_wb_count      = wb_cnt_q;

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed bench for mips_exec_ctrl with a cycle-level reference model.
module tb_mips_exec_ctrl;
  import mips_ctrl_pkg::*;

  localparam int unsigned CNT_W = 6;
  localparam int          DRAIN = 4;
  localparam int          RSTC  = 2;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              halt;
  logic              o_pc_write, o_cpu_rst, o_done;
  logic [2:0]        o_state;
  logic [CNT_W-1:0]  o_cycle_count;
  logic [4:0]        o_last_wb_addr;
  logic [31:0]       o_last_wb_data;
  logic [7:0]        o_wb_count;

  always #5 clk = ~clk;

  mips_exec_ctrl_if bus();

  mips_exec_ctrl #(
    .DRAIN_CYCLES (DRAIN),
    .RST_CYCLES   (RSTC),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .i_halt_fetched (halt),
    .o_pc_write     (o_pc_write),
    .o_cpu_rst      (o_cpu_rst),
    .o_state        (o_state),
    .o_done         (o_done),
    .o_cycle_count  (o_cycle_count),
    .o_last_wb_addr (o_last_wb_addr),
    .o_last_wb_data (o_last_wb_data),
    .o_wb_count     (o_wb_count)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  bit armed = 1'b0;

  // Reference model: state by name, remaining cycles in a timed phase, counters as plain ints.
  int          m_st, m_left, m_cc, m_wbn;
  logic        m_pcw, m_crst, m_done, m_ready;
  logic [4:0]  m_wba;
  logic [31:0] m_wbd;

  // Statistics gathered once per cycle.
  int pcw_hi = 0, done_pulses = 0, drain_cyc = 0, rst_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance the model on each rising edge from the inputs it sees there.
  always @(posedge clk) begin : model
    int ns, nl;
    bit acc, enter_rst;
    logic [1:0] c;
    if (rst) begin
      armed <= 1'b1;
      m_st <= 0; m_left <= 0; m_cc <= 0; m_wbn <= 0;
      m_pcw <= 1'b0; m_crst <= 1'b0; m_done <= 1'b0; m_ready <= 1'b1;
      m_wba <= '0; m_wbd <= '0;
    end else begin
      acc = bus.i_cmd_valid && m_ready;
      c   = bus.i_cmd;
      ns  = m_st;
      nl  = m_left;
      case (m_st)
        0: if (acc) begin
             if (c == 2'b00) ns = 1;
             else if (c == 2'b01) ns = 2;
             else if (c == 2'b11) ns = 5;
           end
        1: if (acc && c == 2'b11) ns = 5;
           else if (halt || (acc && c == 2'b10)) ns = 3;
        2: ns = halt ? 3 : 0;
        3: begin nl = m_left - 1; if (nl == 0) ns = 4; end
        4: if (acc && c == 2'b11) ns = 5;
        5: begin nl = m_left - 1; if (nl == 0) ns = 0; end
        default: ns = 0;
      endcase
      if (ns == 3 && m_st != 3) nl = DRAIN;
      enter_rst = (ns == 5 && m_st != 5);
      if (enter_rst) nl = RSTC;
      m_pcw   <= (ns == 1) || (ns == 2);
      m_crst  <= (ns == 5);
      m_ready <= (ns == 0) || (ns == 1) || (ns == 4);
      m_done  <= (ns == 3) && (nl == 1);
      if (enter_rst) m_cc <= 0;
      else if (m_pcw && m_cc < CMAX) m_cc <= m_cc + 1;
      if (enter_rst) begin
        m_wbn <= 0; m_wba <= '0; m_wbd <= '0;
      end else if (m_st != 5 && bus.i_wb_regwrite) begin
        m_wbn <= (m_wbn + 1) % 256;
        m_wba <= bus.i_wb_addr;
        m_wbd <= bus.i_wb_data;
      end
      m_st   <= ns;
      m_left <= nl;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    chk("state", longint'(o_state), longint'(m_st));
    chk("pc_write", longint'(o_pc_write), longint'(m_pcw));
    chk("cpu_rst", longint'(o_cpu_rst), longint'(m_crst));
    chk("done", longint'(o_done), longint'(m_done));
    chk("cmd_ready", longint'(bus.o_cmd_ready), longint'(m_ready));
    chk("cycle_count", longint'(o_cycle_count), longint'(m_cc));
    chk("wb_count", longint'(o_wb_count), longint'(m_wbn));
    chk("last_wb_addr", longint'(o_last_wb_addr), longint'(m_wba));
    chk("last_wb_data", longint'(o_last_wb_data), longint'(m_wbd));
  endtask

  // Advance n cycles; sample 1 ns after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (armed) begin
        compare_all();
        if (o_pc_write) pcw_hi++;
        if (o_done) done_pulses++;
        if (o_state == 3'd3) drain_cyc++;
        if (o_cpu_rst) rst_hi++;
      end
    end
  endtask

  task automatic send(input logic [1:0] c);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
    tick(1);
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget);
    int k = 0;
    while (int'(o_state) != s && k < budget) begin
      tick(1);
      k++;
    end
    chk("wait_state", longint'(o_state), longint'(s));
  endtask

  initial begin
    int p0, d0, dr0, r0, h;
    rst = 1'b1;
    halt = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = 2'b00;
    bus.i_wb_regwrite = 1'b0;
    bus.i_wb_addr = '0;
    bus.i_wb_data = '0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Reset values
    chk("lit_rst_state", longint'(o_state), 0);
    chk("lit_rst_pcw", longint'(o_pc_write), 0);
    chk("lit_rst_ready", longint'(bus.o_cmd_ready), 1);
    chk("lit_rst_cc", longint'(o_cycle_count), 0);

    // RUN, then halt 20 cycles later
    p0 = pcw_hi;
    send(2'b00);
    chk("lit_run_rise", longint'(o_pc_write), 1);
    tick(19);
    h = cyc;
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("lit_halt_pcw_drop", longint'(o_pc_write), 0);
    tick(3);
    chk("lit_done_at_h_plus_4", longint'(o_done), 1);
    chk("lit_done_cycle", longint'(cyc - h), 4);
    tick(1);
    chk("lit_state_done", longint'(o_state), 4);
    chk("lit_pcw_cycles", longint'(pcw_hi - p0), 20);
    chk("lit_cc_20", longint'(o_cycle_count), 20);

    // DONE ignores RUN
    send(2'b00);
    chk("lit_done_ignores_run", longint'(o_state), 4);

    // CPU_RESET from DONE
    r0 = rst_hi;
    send(2'b11);
    chk("lit_cpurst_cc_clear", longint'(o_cycle_count), 0);
    chk("lit_cpurst_ready", longint'(bus.o_cmd_ready), 0);
    tick(2);
    chk("lit_cpurst_len", longint'(rst_hi - r0), 2);
    chk("lit_cpurst_to_idle", longint'(o_state), 0);

    // Three single steps, 5 cycles apart
    p0 = pcw_hi;
    repeat (3) begin
      send(2'b01);
      tick(4);
    end
    chk("lit_step_pulses", longint'(pcw_hi - p0), 3);
    chk("lit_step_cc", longint'(o_cycle_count), 3);

    // RUN, ignore STEP, then STOP and halt together
    d0 = done_pulses;
    dr0 = drain_cyc;
    send(2'b00);
    send(2'b01);
    chk("lit_run_ignores_step", longint'(o_state), 1);
    tick(3);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd = 2'b10;
    halt = 1'b1;
    tick(1);
    bus.i_cmd_valid = 1'b0;
    halt = 1'b0;
    tick(8);
    chk("lit_single_done", longint'(done_pulses - d0), 1);
    chk("lit_drain_len", longint'(drain_cyc - dr0), 4);

    // CPU_RESET then RUN accepted, then STOP
    send(2'b11);
    tick(2);
    chk("lit_idle_after_rst", longint'(o_state), 0);
    send(2'b00);
    chk("lit_run_after_rst", longint'(o_pc_write), 1);
    tick(2);
    send(2'b10);
    wait_state(4, 20);

    // Write-backs during CPU_RESET are dropped and cleared
    bus.i_wb_regwrite = 1'b1;
    bus.i_wb_addr = 5'd7;
    bus.i_wb_data = 32'h1234;
    send(2'b11);
    tick(2);
    bus.i_wb_regwrite = 1'b0;
    chk("lit_wb_cleared", longint'(o_wb_count), 0);
    wait_state(0, 10);

    // 260 write-backs wrap the count to 4
    for (int i = 0; i < 260; i++) begin
      bus.i_wb_regwrite = 1'b1;
      bus.i_wb_addr = (i == 259) ? 5'd5 : 5'(i % 32);
      bus.i_wb_data = (i == 259) ? 32'hDEAD_BEEF : 32'(i) * 32'h0101_0101;
      tick(1);
    end
    bus.i_wb_regwrite = 1'b0;
    tick(1);
    chk("lit_wb_count", longint'(o_wb_count), 4);
    chk("lit_wb_addr", longint'(o_last_wb_addr), 5);
    chk("lit_wb_data", longint'(o_last_wb_data), 64'hDEAD_BEEF);

    // Cycle counter saturates
    send(2'b00);
    tick(70);
    chk("lit_cc_sat", longint'(o_cycle_count), longint'(CMAX));
    send(2'b10);
    wait_state(4, 20);

    // Reset mid-DRAIN
    send(2'b11);
    wait_state(0, 10);
    send(2'b00);
    tick(3);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    tick(2);
    chk("lit_in_drain", longint'(o_state), 3);
    d0 = done_pulses;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("lit_rstdrain_state", longint'(o_state), 0);
    chk("lit_rstdrain_done", longint'(o_done), 0);
    chk("lit_rstdrain_cc", longint'(o_cycle_count), 0);
    tick(6);
    chk("lit_rstdrain_no_done", longint'(done_pulses - d0), 0);

    // Reset mid-CPURST
    send(2'b00);
    tick(2);
    send(2'b11);
    chk("lit_in_cpurst", longint'(o_cpu_rst), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("lit_rstcpurst_drop", longint'(o_cpu_rst), 0);
    chk("lit_rstcpurst_state", longint'(o_state), 0);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mips_exec_ctrl.md
# mips_exec_ctrl

Execution controller for the 5-stage MIPS core. Owns the core's PC-write enable and a core-reset pulse, and accepts run/step/stop/reset commands from the debug front-end over a valid/ready handshake. It detects program halt, drains the pipeline, then reports completion. It also captures every write-back so the last register result and a write-back count can be read back.

## Interface
- `DRAIN_CYCLES`, default 4: cycles to wait after PC freeze so in-flight instructions retire through WB.
- `RST_CYCLES`, default 2: length of the `o_cpu_rst` pulse.
- `CNT_W`, default 32: width of the executed-cycle counter.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset of this block.
- `i_cmd_valid` in 1: command present.
- `i_cmd` in 2: command code. 00 RUN, 01 STEP, 10 STOP, 11 CPU_RESET.
- `o_cmd_ready` out 1: command accepted this cycle when high together with `i_cmd_valid`.
- `i_halt_fetched` in 1: fetch stage holds the HALT opcode (all-ones word).
- `i_wb_regwrite` in 1: write-back stage is writing the register file.
- `i_wb_addr` in 5: write-back destination register.
- `i_wb_data` in 32: write-back data.
- `o_pc_write` out 1: drives the core's `i_PC_write`.
- `o_cpu_rst` out 1: core reset pulse. The top level ORs it with `rst`.
- `o_state` out 3: current FSM state encoding.
- `o_done` out 1: one-cycle pulse when the drain completes.
- `o_cycle_count` out `CNT_W`: cycles with `o_pc_write`=1, saturating.
- `o_last_wb_addr` out 5, `o_last_wb_data` out 32: most recent write-back.
- `o_wb_count` out 8: number of write-backs, wraps modulo 256.

## Operation
- States and encodings: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4, CPURST=5.
- Reset values:
  - state IDLE.
  - `o_pc_write`, `o_cpu_rst`, `o_done` = 0.
  - all counters and capture registers = 0.
- `o_cmd_ready`=1 in IDLE, RUN and DONE; 0 in STEP, DRAIN and CPURST.
- IDLE transitions:
  - RUN → RUN.
  - STEP → STEP.
  - CPU_RESET → CPURST.
  - STOP is accepted and ignored.
- RUN: `o_pc_write`=1.
  - `i_halt_fetched` or an accepted STOP → DRAIN.
  - Accepted CPU_RESET → CPURST; this has priority over halt and STOP.
  - RUN and STEP are accepted and ignored.
- STEP: `o_pc_write`=1 for exactly one cycle, then IDLE. If `i_halt_fetched` is high in that cycle, go to DRAIN instead.
- DRAIN: `o_pc_write`=0. A down-counter is loaded with `DRAIN_CYCLES`-1 on entry. When it reaches 0: pulse `o_done` and go to DONE.
- DONE: `o_pc_write`=0. Only CPU_RESET is acted on (→ CPURST); other commands are accepted and ignored.
- CPURST: `o_cpu_rst`=1 and `o_pc_write`=0 for `RST_CYCLES` cycles. At entry, clear `o_cycle_count`, `o_wb_count` and the capture registers. Then go to IDLE.
- Cycle counter: increments in every cycle where `o_pc_write`=1 and holds at all-ones.
- Write-back capture: runs in every state except CPURST. When `i_wb_regwrite`=1, latch `i_wb_addr` and `i_wb_data` and increment `o_wb_count`. Writes to `i_wb_addr`=0 are captured too.

## Timing
- All outputs are registered.
- A command accepted in cycle N produces its state and outputs in cycle N+1; e.g. `o_pc_write` rises at N+1 after a RUN.
- Halt seen in cycle N:
  - `o_pc_write`=0 from N+1.
  - `o_done` pulses at N+`DRAIN_CYCLES`.
  - state is DONE at N+`DRAIN_CYCLES`+1.
- Simultaneous halt and accepted STOP: single DRAIN entry, no double counting.
- `rst` in any state, including mid-DRAIN or mid-CPURST: next cycle everything is at reset values and `o_cpu_rst` drops immediately.
- `o_cycle_count` at all-ones: stays all-ones. `o_wb_count` at 255 plus one write-back: becomes 0.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state encodings.
  - command codes.
  - the HALT opcode constant (32'hFFFF_FFFF).
  - default `DRAIN_CYCLES` and `RST_CYCLES`.
- One sub-module, `mips_ctrl_sat_counter`: parameterised width, synchronous clear, enable, saturate. Used for the cycle counter. The drain and reset down-counters stay inline.

## Test plan
- RUN accepted at cycle 10, `i_halt_fetched` at cycle 30:
  - `o_pc_write` high cycles 11–30.
  - `o_done` at 34.
  - DONE at 35.
  - `o_cycle_count`=20.
- Three STEP commands from IDLE, 5 cycles apart → exactly three one-cycle `o_pc_write` pulses; `o_cycle_count`=3.
- RUN, then STOP and halt in the same cycle → one DRAIN of 4 cycles and one `o_done` pulse.
- From DONE, send CPU_RESET:
  - `o_cpu_rst` high for 2 cycles.
  - counters and capture registers read 0.
  - state returns to IDLE.
  - RUN is accepted afterwards.
- 260 write-backs, the last with addr=5 and data=32'hDEAD_BEEF → `o_wb_count`=4, `o_last_wb_addr`=5, `o_last_wb_data`=32'hDEAD_BEEF.
- Assert `rst` mid-DRAIN and separately mid-CPURST → all outputs at reset values the next cycle and no `o_done` pulse.
